// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and types for the clk_divider block
//
// Purpose : counter width, counter type and reset level used by clk_divider
//           and its reset synchronizer.
// Ports   : none (package)
package clk_div_pkg;

   localparam int CLK_DIV_WIDTH = 4;

   typedef logic [CLK_DIV_WIDTH-1:0] clk_div_cnt_t;

   // Level of the external reset pin that means "in reset"
   localparam logic CLK_DIV_RST_ACTIVE = 1'b0;

endpackage

// File: rtl/clk_div_rst_sync.sv
// rtl/clk_div_rst_sync.sv - 2-flop reset synchronizer, async assert / sync release
//
// Purpose : turns the asynchronous board reset into a reset that asserts
//           immediately and releases cleanly relative to clk.
// Ports   : i_clk    system clock
//           i_rst_n  raw asynchronous reset, active low
//           o_rst_n  synchronized reset, active low
module clk_div_rst_sync
   import clk_div_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_rst_n
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (i_rst_n == CLK_DIV_RST_ACTIVE) begin
         r_meta <= 1'b0;
      end else begin
         r_meta <= 1'b1;
      end
   end

   // Second stage captures on the falling edge: it still gives the first
   // stage half a cycle to settle, and lets the counter leave reset in time
   // to take its first step on the second rising edge after release.
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (i_rst_n == CLK_DIV_RST_ACTIVE) begin
         r_sync <= 1'b0;
      end else begin
         r_sync <= r_meta;
      end
   end

   assign o_rst_n = r_sync;

endmodule

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - power-of-two divider: /2 /4 /8 /16 from one free-running counter
//
// Purpose : all divided outputs are bits of one registered counter, so they are
//           glitch-free and change together on the rising edge of clk.
//           Optional one-cycle strobes are built when CLK_DIV_TICK_EN is defined.
// Ports   : clk        system clock, rising edge
//           reset      asynchronous reset, active low
//           clk_div2   clk / 2  (cnt[0])
//           clk_div4   clk / 4  (cnt[1])
//           clk_div8   clk / 8  (cnt[2])
//           clk_div16  clk / 16 (cnt[3])
//           tick_divN  high in the last cycle of each clk_divN period
//                      (CLK_DIV_TICK_EN only)
module clk_divider
   import clk_div_pkg::*;
#(
   parameter int WIDTH = CLK_DIV_WIDTH
)
(
   input  logic clk,
   input  logic reset,
   output logic clk_div2,
   output logic clk_div4,
   output logic clk_div8,
   output logic clk_div16
`ifdef CLK_DIV_TICK_EN
   ,
   output logic tick_div2,
   output logic tick_div4,
   output logic tick_div8,
   output logic tick_div16
`endif
);

   logic             w_rst_n;
   clk_div_cnt_t     r_cnt;
   logic [WIDTH-1:0] w_cnt_next;

   clk_div_rst_sync u_rst_sync (
      .i_clk   (clk),
      .i_rst_n (reset),
      .o_rst_n (w_rst_n)
   );

   // Natural 4-bit wrap gives 15 -> 0 with no stall
   assign w_cnt_next = r_cnt + clk_div_cnt_t'(1);

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   assign clk_div2  = r_cnt[0];
   assign clk_div4  = r_cnt[1];
   assign clk_div8  = r_cnt[2];
   assign clk_div16 = r_cnt[3];

`ifdef CLK_DIV_TICK_EN
   // Low log2(N) bits all ones = last cycle of a clk_divN period
   assign tick_div2  = r_cnt[0];
   assign tick_div4  = &r_cnt[1:0];
   assign tick_div8  = &r_cnt[2:0];
   assign tick_div16 = &r_cnt[3:0];
`endif

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - scoreboard bench for clk_divider
`timescale 1ns/100ps
module tb_clk_divider;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic clk_div2, clk_div4, clk_div8, clk_div16;
`ifdef CLK_DIV_TICK_EN
   logic tick_div2, tick_div4, tick_div8, tick_div16;
`endif

   clk_divider #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_div2   (clk_div2),
      .clk_div4   (clk_div4),
      .clk_div8   (clk_div8),
      .clk_div16  (clk_div16)
`ifdef CLK_DIV_TICK_EN
      ,
      .tick_div2  (tick_div2),
      .tick_div4  (tick_div4),
      .tick_div8  (tick_div8),
      .tick_div16 (tick_div16)
`endif
   );

   always #2.5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb_q[$];
   int         m_edges  = 0;
   logic       rip_en   = 1'b0;
   logic       prev_ok  = 1'b0;
   logic [3:0] prev_div = 4'b0;
   real        last_rise[4];
   int         per_x10[4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {ticks16..2, div16..2} after the given number of rising edges
   // seen since reset release; the counter first steps on edge 2.
   function automatic logic [7:0] model(input int edges);
      int         c;
      logic [7:0] v;
      c = (edges >= 2) ? ((edges - 1) % 16) : 0;
      v[3:0] = c[3:0];
`ifdef CLK_DIV_TICK_EN
      v[4] = ((c % 2)  == 1);
      v[5] = ((c % 4)  == 3);
      v[6] = ((c % 8)  == 7);
      v[7] = ((c % 16) == 15);
`else
      v[7:4] = 4'b0;
`endif
      return v;
   endfunction

   function automatic logic [7:0] sample();
`ifdef CLK_DIV_TICK_EN
      return {tick_div16, tick_div8, tick_div4, tick_div2,
              clk_div16, clk_div8, clk_div4, clk_div2};
`else
      return {4'b0, clk_div16, clk_div8, clk_div4, clk_div2};
`endif
   endfunction

   task automatic clear_rise();
      for (int k = 0; k < 4; k++) last_rise[k] = -1.0;
      prev_ok = 1'b0;
   endtask

   task automatic step(input int n);
      logic [7:0] got;
      logic [7:0] exp;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (reset) m_edges++;
         sb_q.push_back(model(m_edges));
         @(negedge clk);
         got = sample();
         exp = sb_q.pop_front();
         chk("seq", {24'd0, got}, {24'd0, exp});
         if (rip_en && prev_ok) begin
            for (int k = 1; k < 4; k++)
               chk("ripple", {31'd0, got[k] ^ prev_div[k]}, {31'd0, prev_div[k-1] & ~got[k-1]});
         end
         for (int k = 0; k < 4; k++) begin
            if (prev_ok && got[k] && !prev_div[k]) begin
               if (last_rise[k] >= 0.0) per_x10[k] = int'(($realtime - last_rise[k]) * 10.0);
               last_rise[k] = $realtime;
            end
         end
         prev_div = got[3:0];
         prev_ok  = 1'b1;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got;
      logic [7:0] cur;
      int         guard;
      for (int k = 0; k < 4; k++) per_x10[k] = 0;
      clear_rise();

      #1;
      chk("rst_state", {24'd0, sample()}, 32'h0);
      step(20);

      reset  = 1'b1;
      rip_en = 1'b1;
      step(33);
      rip_en = 1'b0;
      chk("per_div2",  per_x10[0], 100);
      chk("per_div4",  per_x10[1], 200);
      chk("per_div8",  per_x10[2], 400);
      chk("per_div16", per_x10[3], 800);

      guard = 0;
      cur   = model(m_edges);
      while (cur[3:0] != 4'd11 && guard < 32) begin
         step(1);
         cur = model(m_edges);
         guard++;
      end
      got = sample();
      chk("pre_clr", {28'd0, got[3:0]}, 32'd11);

      reset   = 1'b0;
      m_edges = 0;
      clear_rise();
      #1;
      chk("async_clr", {24'd0, sample()}, 32'h0);
      @(negedge clk);
      step(2);
      reset = 1'b1;
      step(18);

      reset   = 1'b0;
      m_edges = 0;
      step(3);
      #2.3;
      reset = 1'b1;
      step(1);
      chk("near_edge_hold", {24'd0, sample()}, 32'h0);
      step(1);
      got = sample();
      chk("near_edge_first", {28'd0, got[3:0]}, 32'd1);
      step(32);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_divider.md
# clk_divider

Synchronous power-of-two clock divider producing ÷2, ÷4, ÷8 and ÷16 derived signals from one system clock. It sits next to the board clock input and drives status LEDs and slow-rate logic. All outputs are registered bits of a single free-running binary counter, so they are glitch-free and phase-aligned to the rising edge of `clk`. The outputs are data signals; they are not for use as clocks without a clock buffer.

## Interface
- `WIDTH`, default 4: counter width, i.e. the number of divided outputs. It is fixed at 4 for this block; other values are unsupported.
- `clk`  input  1  system clock, rising-edge active.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `clk_div2`  output  1  `clk` ÷ 2, 50% duty.
- `clk_div4`  output  1  `clk` ÷ 4, 50% duty.
- `clk_div8`  output  1  `clk` ÷ 8, 50% duty.
- `clk_div16`  output  1  `clk` ÷ 16, 50% duty.
- `tick_div2`, `tick_div4`, `tick_div8`, `tick_div16`  output  1 each  one-cycle strobes. Present only with `CLK_DIV_TICK_EN`.

## Operation
- Internal state is a 4-bit counter `cnt`.
- `cnt` increments by 1 on every rising `clk` edge while `reset` is high.
- `cnt` wraps from 15 to 0 with no stall.
- Output mapping: `clk_div2` = `cnt[0]`, `clk_div4` = `cnt[1]`, `clk_div8` = `cnt[2]`, `clk_div16` = `cnt[3]`.
- There is no enable input and no load input; the counter is free-running.
- Reset (`reset` = 0) clears `cnt` to 0 immediately, with no clock required. All outputs read 0 and all ticks read 0 while reset is held.
- Reset asserted mid-count: the count is discarded. Counting restarts from 0 after release and there is no phase memory.
- Each `tick_divN` is high while the low log2(N) bits of `cnt` are all 1. It therefore marks the last `clk` cycle of every `clk_divN` period. It is decoded from `cnt` and is low during reset.

## Timing
- Reset values: `cnt` = 0, `clk_div2/4/8/16` = 0, ticks = 0.
- Deassertion of `reset` is synchronized by a 2-flop release synchronizer. Assertion remains asynchronous.
- The first increment happens on the 2nd rising edge after `reset` rises. That edge moves `cnt` from 0 to 1, so `clk_div2` goes to 1.
- Each output changes only clk-to-q after a rising `clk` edge. All outputs change on the same edge, so there is no ripple skew.
- Periods are 2, 4, 8 and 16 `clk` cycles, each high for exactly half its period.
- On the edge where `cnt` wraps 15→0, all four outputs fall together.

## Configuration
- Macro `CLK_DIV_TICK_EN`:
  - Defined: the four `tick_divN` ports and their decode logic exist.
  - Undefined: the ports and logic are absent, and the divided outputs behave identically either way.

## Structure
- Package `clk_div_pkg` holds:
  - `CLK_DIV_WIDTH` = 4.
  - Counter typedef `clk_div_cnt_t` (logic [3:0]).
  - Reset-level constant `CLK_DIV_RST_ACTIVE` = 1'b0.
- One sub-module, `clk_div_rst_sync`, the 2-flop async-assert / sync-release reset synchronizer.
- Counter, output mapping and tick decode live in the top module.

## Test plan
- Hold `reset` = 0 for 100 ns with `clk` at a 5 ns period -> all outputs and ticks stay 0 throughout.
- Release `reset`, then run 32 cycles:
  - From the first increment, {div16, div8, div4, div2} steps 0001, 0010, … 1111, 0000.
  - Periods measured as 10 / 20 / 40 / 80 ns.
- Sample at every rising edge -> `clk_div4` toggles exactly when `clk_div2` falls, and likewise for each higher stage.
- Assert `reset` = 0 asynchronously mid-cycle at `cnt` = 11 -> outputs go to 0000 before the next `clk` edge. After release, the sequence restarts at 0001.
- With `CLK_DIV_TICK_EN`, run 32 cycles -> `tick_div16` is high exactly one cycle, at `cnt` = 15, once per 16 cycles. `tick_div2` is high every other cycle.
- Release `reset` close to a `clk` edge -> no output change within that cycle; the first increment lands cleanly on the 2nd edge.
